serial_signed_comparator: RTL and testbench
===========================================

Name: serial_signed_comparator

Overview:
- Multi-cycle, digit-serial magnitude comparator: the sequential, area-reduced counterpart of the team's flat 32-bit signed less-than-or-equal comparator.
- Accepts an operand pair (a, b) through a valid/ready handshake and scans them LSB-first, DIGIT bits per cycle.
- Returns le / lt / eq through a second valid/ready handshake.
- Used in the crypto datapath wherever a single shared compare unit replaces several parallel comparators.

Parameters:
- WIDTH, 32, operand width in bits; WIDTH >= 2.
- DIGIT, 4, bits consumed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- NDIG (derived, not overridable), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  left operand, two's complement when is_signed=1
- b  input  WIDTH  right operand
- is_signed  input  1  1 = signed compare, 0 = unsigned; captured with operands
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- le  output  1  a <= b
- lt  output  1  a < b
- eq  output  1  a == b

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, asserted asynchronously; release is synchronised externally):
  - state = IDLE; out_valid = 0; le = lt = eq = 0.
  - Shift registers, digit counter and flags cleared.
  - in_ready = 1 while in IDLE, including during reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: capture a into sa, b into sb, is_signed into sg.
  - Set cnt = 0, lt_acc = 0, eq_acc = 1, go to RUN.
- RUN (in_ready = 0, out_valid = 0), once per cycle:
  - da = sa[DIGIT-1:0], db = sb[DIGIT-1:0].
  - If cnt != NDIG-1, compare da vs db unsigned.
  - If cnt == NDIG-1 and sg = 1, compare da vs db as DIGIT-bit signed values (MSB of the digit is the sign). Unsigned otherwise.
  - If da != db: lt_acc <= (da < db) under the rule above. Else lt_acc holds.
  - eq_acc <= eq_acc & (da == db).
  - sa and sb shift right by DIGIT; cnt increments.
  - When cnt == NDIG-1, go to DONE.
- Higher digits override lower ones. Final lt_acc is the full-width result.
- DONE:
  - out_valid = 1; lt = lt_acc, eq = eq_acc, le = lt_acc | eq_acc.
  - Outputs are registered and stable while out_valid = 1 and out_ready = 0.
  - On out_ready: go to IDLE. out_valid drops next cycle; le/lt/eq hold their last values.
- Latency: operands accepted at edge k; out_valid high after edge k+NDIG (8 cycles at defaults).
- Throughput: one compare per NDIG+2 cycles minimum. No overlap: in_ready = 0 in RUN and DONE.
- Boundary conditions:
  - in_valid while busy is ignored; operands are not captured.
  - in_valid and out_ready in the same DONE cycle: result is consumed, and the new operands are accepted only on the following IDLE cycle.
  - Changes on a / b / is_signed after capture have no effect.
  - Reset mid-RUN or mid-DONE aborts the operation, drops out_valid immediately and returns to IDLE. No partial result is ever presented.
  - Extreme values: 0x80000000 vs 0x7FFFFFFF and 0xFFFFFFFF vs 0 must follow signed or unsigned semantics per sg.
- No combinational path from input to output except in_ready and out_valid, which decode state.

Test Plan:
- Signed extremes: a=0x80000000, b=0x7FFFFFFF, is_signed=1 -> lt=1 le=1 eq=0. Same operands with is_signed=0 -> lt=0 le=0 eq=0.
- Equality: a=b=0xDEADBEEF, is_signed=1 -> eq=1 le=1 lt=0, out_valid exactly 8 cycles after acceptance.
- Higher digit overrides lower: a=0x12345670, b=0x1234566F, is_signed=1 -> lt=0 le=0 eq=0. Swap the operands -> lt=1 le=1.
- Sign of negative one: a=0xFFFFFFFF, b=0x00000000, is_signed=1 -> lt=1 le=1. With is_signed=0 -> lt=0 le=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs stable, in_ready=0, new operands not captured. After out_ready, the next operand pair completes correctly.
- Reset mid-operation: assert rst_n=0 at RUN cycle 3 -> out_valid=0 and le/lt/eq=0 immediately, in_ready=1. After release, a=5, b=5 -> eq=1 le=1.

Source files
------------

// File: rtl/serial_signed_comparator.sv
// serial_signed_comparator
// Digit-serial magnitude comparator. Operands are captured through a
// valid/ready handshake, scanned LSB-first DIGIT bits per cycle, and the
// le/lt/eq result is returned through a second valid/ready handshake.
// Higher digits override lower ones, so the accumulated less-than flag after
// the last (most significant) digit is the full-width answer. For signed
// compares only the top digit is treated as two's complement.

module serial_signed_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             le,
    output logic             lt,
    output logic             eq
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_signed_comparator: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic             sg;
    logic [CW-1:0]    cnt;
    logic             lt_acc, eq_acc;

    logic [DIGIT-1:0] da, db;
    logic             last;
    logic             dig_lt;
    logic             lt_nx, eq_nx;

    // Per-digit compare and the next values of the running flags.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch is inferred.
        da     = sa[DIGIT-1:0];
        db     = sb[DIGIT-1:0];
        last   = (cnt == CW'(NDIG - 1));
        dig_lt = (da < db);
        if (last && sg) begin
            // Top digit of a signed operand: its MSB carries the sign.
            dig_lt = ($signed(da) < $signed(db));
        end
        lt_nx = (da != db) ? dig_lt : lt_acc;
        eq_nx = eq_acc & (da == db);
    end

    // Next-state decode for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)  state_nx = RUN;
            RUN:  if (last)      state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values sampled at the clock edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand shift registers, digit counter, running flags and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sg     <= 1'b0;
            cnt    <= '0;
            lt_acc <= 1'b0;
            eq_acc <= 1'b0;
            le     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= b;
                        sg     <= is_signed;
                        cnt    <= '0;
                        lt_acc <= 1'b0;
                        eq_acc <= 1'b1;
                    end
                end
                RUN: begin
                    sa     <= sa >> DIGIT;
                    sb     <= sb >> DIGIT;
                    cnt    <= cnt + CW'(1);
                    lt_acc <= lt_nx;
                    eq_acc <= eq_nx;
                    // Result registers load only from a completed scan, so a
                    // partial result is never visible on the outputs.
                    if (last) begin
                        lt <= lt_nx;
                        eq <= eq_nx;
                        le <= lt_nx | eq_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_serial_signed_comparator.sv
// tb_serial_signed_comparator
// Drives directed corner cases and randomized operand pairs into the serial
// comparator and checks le/lt/eq, latency and handshake behaviour against a
// whole-word arithmetic reference.

module tb_serial_signed_comparator;

    localparam int W       = 32;
    localparam int LATENCY = 8;
    localparam int TIMEOUT = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic         le, lt, eq;

    int vectors     = 0;
    int miscompares = 0;

    serial_signed_comparator #(.WIDTH(W), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .le        (le),
        .lt        (lt),
        .eq        (eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Whole-word reference: {le, lt, eq}.
    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic l, e;
        l = s ? ($signed(x) < $signed(y)) : (x < y);
        e = (x == y);
        return {l | e, l, e};
    endfunction

    // Present operands at a falling edge and return after the accepting rising edge.
    task automatic offer(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(n < TIMEOUT), 32'd1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        // Disturb inputs after capture; they must not affect the result.
        a         = $urandom;
        b         = $urandom;
        is_signed = ~s;
    endtask

    // Called at the falling edge after acceptance: wait for out_valid, check
    // latency and result, leave the result pending (out_ready low).
    task automatic wait_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s);
        int lat = 0;
        logic [2:0] exp;
        exp = model(x, y, s);
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        check({tag, "_lelteq"}, 32'({le, lt, eq}), 32'(exp));
    endtask

    // Consume the pending result and check that out_valid drops while le/lt/eq hold.
    task automatic consume(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s);
        logic [2:0] exp;
        exp = model(x, y, s);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'({out_valid, in_ready}), 32'b01);
        check({tag, "_hold"}, 32'({le, lt, eq}), 32'(exp));
    endtask

    task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s);
        offer(x, y, s);
        wait_result(tag, x, y, s);
        consume(tag, x, y, s);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [2:0]   held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;

        #12;
        check("reset_state", 32'({in_ready, out_valid, le, lt, eq}), 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        run("smin_vs_smax_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        run("smin_vs_smax_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        run("equal_s",        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        run("hi_digit",       32'h1234_5670, 32'h1234_566F, 1'b1);
        run("hi_digit_swap",  32'h1234_566F, 32'h1234_5670, 1'b1);
        run("neg1_vs_0_s",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run("neg1_vs_0_u",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run("zero_eq_u",      32'h0000_0000, 32'h0000_0000, 1'b0);

        // Backpressure: result pending for 5 cycles while new operands are offered.
        offer(32'h0000_0003, 32'hFFFF_FFFE, 1'b1);
        wait_result("bp_first", 32'h0000_0003, 32'hFFFF_FFFE, 1'b1);
        held = model(32'h0000_0003, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            a         = 32'h0000_0010;
            b         = 32'h0000_0020;
            is_signed = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("bp_stable", 32'({out_valid, in_ready, le, lt, eq}), 32'({2'b10, held}));
        end
        // Consume while in_valid is still high: new pair only taken in IDLE.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", 32'({out_valid, in_ready}), 32'b01);
        @(posedge clk);          // accepting edge for 0x10 vs 0x20
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h0000_0020;
        b        = 32'h0000_0010;
        wait_result("bp_second", 32'h0000_0010, 32'h0000_0020, 1'b0);
        consume("bp_second", 32'h0000_0010, 32'h0000_0020, 1'b0);

        // Reset mid-RUN after a result that left eq/le set.
        run("pre_reset", 32'h0000_0042, 32'h0000_0042, 1'b0);
        offer(32'h8000_0000, 32'h0000_0001, 1'b1);
        @(posedge clk);
        @(posedge clk);          // now in RUN cycle 3
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", 32'({in_ready, out_valid, le, lt, eq}), 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", 32'd5, 32'd5, 1'b0);

        // Randomized pairs, biased toward shared upper digits and equality.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(31));
                2:       rb = {ra[31:16], 16'($urandom)};
                default: rb = $urandom;
            endcase
            run("random", ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
